// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters.
// Arbitrates, runs one access cycle, waits a fixed latency, returns data.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request and address (held until done)
//   if_gnt/if_done/if_rdata  fetch accepted / complete pulses, fetched word
//   d_req/d_we/d_addr/d_wdata data request, direction, address, store data
//   d_gnt/d_done/d_rdata     data accepted / complete pulses, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro port
//   busy                     arbiter is not idle
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_PRIO   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_D  = 1'b1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              pick_d;

    // On a tie, round-robin favours whichever port was not served last.
    always_comb begin
        pick_d = 1'b0;
        unique case (1'b1)
            (d_req && !if_req): pick_d = 1'b1;
            (d_req && if_req):
                pick_d = (DATA_PRIO != 0) ? 1'b1
                                          : (last_grant == PORT_IF);
            default: pick_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= PORT_IF;
            last_grant <= PORT_D;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner   <= pick_d;
                        addr_q  <= pick_d ? d_addr : if_addr;
                        we_q    <= pick_d & d_we;
                        wdata_q <= pick_d ? d_wdata : '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt   <= WAIT_LD;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!we_q) begin
                            if (owner == PORT_D) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come from state/owner only, so reset clears them at once.
    assign busy      = (state != IDLE);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = mem_en & (owner == PORT_IF);
    assign d_gnt     = mem_en & (owner == PORT_D);
    assign if_done   = (state == DONE) & (owner == PORT_IF);
    assign d_done    = (state == DONE) & (owner == PORT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (IFID stage) and the data requester (MR/MW stages) of the multicycle core.
- Each requester issues one transaction at a time and holds it until completion. The arbiter picks a winner, drives the memory port for one access cycle, waits a fixed latency, then returns read data or a write acknowledgement.
- It sits between the control unit/datapath and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, cycles from the mem_en cycle's closing edge until mem_rdata is valid. Legal range 1..15.
- DATA_PRIO, 0, 0 = round-robin on ties; 1 = data port always wins ties.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request (level).
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch transaction accepted (1-cycle pulse).
- if_done  out  1  fetch complete, if_rdata valid (1-cycle pulse).
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request (level).
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data transaction accepted (1-cycle pulse).
- d_done  out  1  data complete; d_rdata valid if read (1-cycle pulse).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset.** rst low, asynchronous:
  - state = IDLE, counter = 0, last_grant = DATA, owner = IF.
  - All outputs are 0: gnt, done, rdata registers, mem_* and busy.
  - mem_en drops immediately, even mid-transaction. The aborted transaction is lost; no done is issued.
- **States:** IDLE, ACCESS, WAIT, DONE.
- **IDLE.**
  - Requests are sampled only in IDLE.
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high:
    - DATA_PRIO = 1: data wins.
    - DATA_PRIO = 0: the port not equal to last_grant wins.
  - On the edge: latch owner, address, we (IF forces we = 0) and wdata; go to ACCESS.
- **ACCESS** (exactly 1 cycle):
  - Outputs: mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values, owner's gnt = 1.
  - On the edge: load counter = WAIT_CYCLES; go to WAIT.
- **WAIT:**
  - mem_en = 0. mem_addr is held at the latched value.
  - Counter decrements each edge.
  - In the cycle where counter == 1: capture mem_rdata into the owner's rdata register (reads only), go to DONE.
  - Writes also pass through WAIT for WAIT_CYCLES cycles.
- **DONE** (exactly 1 cycle):
  - Owner's done = 1.
  - Owner's rdata holds the captured word. It also remains stable after DONE until that port's next capture.
  - Update last_grant = owner; go to IDLE.
- **Latency.**
  - With req first high in cycle 0 and the arbiter idle: gnt in cycle 1, done in cycle 2 + WAIT_CYCLES.
  - Back-to-back transactions are separated by one IDLE cycle.
- **Requester rules.**
  - Hold req, addr, we and wdata until done.
  - A req still high in the IDLE cycle after done is treated as a new request.
  - A req dropped mid-transaction is ignored; the transaction completes and done is still pulsed.
- **Loser port.** No gnt; the request stays pending and is reconsidered in the next IDLE.
- **Output registration.**
  - gnt, done, mem_en, mem_we and busy are decoded from state and owner only, with no input-to-output combinational path.
  - At most one of if_done/d_done and one of if_gnt/d_gnt is high in any cycle.
- **Counter.** 4 bits; never wraps, because it is reloaded in ACCESS.

Test Plan:
- **Single fetch.** WAIT_CYCLES = 1, if_req = 1, if_addr = 0x10, memory returns 0xDEADBEEF:
  - if_gnt in cycle 1, mem_en = 1 with mem_addr = 0x10 in cycle 1.
  - if_done in cycle 3 with if_rdata = 0xDEADBEEF; busy high cycles 1–3.
- **Data write.** d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, WAIT_CYCLES = 3:
  - mem_en = mem_we = 1 for exactly one cycle with those values.
  - d_done in cycle 5; d_rdata unchanged.
- **Round-robin tie.** DATA_PRIO = 0, both reqs held high from reset:
  - Grant order IF, DATA, IF, DATA.
  - Never two gnt or two done pulses in the same cycle.
- **Fixed-priority tie.** DATA_PRIO = 1, both held high:
  - d_gnt on every transaction; if_req pending until d_req drops, then IF is served.
- **Reset mid-transaction.** rst driven low during WAIT of a read:
  - mem_en, busy, gnt and done are 0 immediately.
  - After release: state IDLE, no done for the aborted read; the next tie is granted to IF.
- **Req drop mid-transaction.** d_req dropped during WAIT:
  - Transaction still completes with d_done.
  - If_req pending since cycle 0 is granted in the IDLE cycle after DONE.
